// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response handshake plus the word-addressed data memory port
// of the load/store unit, grouped so the LSU takes a single bundle.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 16
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_we;
  logic [2:0]        i_req_funct3;
  logic [31:0]       i_req_wdata;
  logic              o_rsp_valid;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;
  logic [MEM_AW-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_bmask;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  // LSU side
  modport slave (
    input  i_req_valid, i_req_addr, i_req_we, i_req_funct3, i_req_wdata, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );

  // core + memory side
  modport master (
    output i_req_valid, i_req_addr, i_req_we, i_req_funct3, i_req_wdata, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns byte-addressed RV32 loads/stores into one or two
// byte-masked word accesses, splitting misaligned ones, and extends load data.
module lsu_mem_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int MEM_AW    = 16,
  parameter int MEM_DEPTH = 64000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e            state_q, state_d;
  logic [MEM_AW+1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd0_q, rd0_d, rd1_q, rd1_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  function automatic logic [2:0] acc_size(input logic [1:0] f);
    case (f)
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

  // Accept-time checks on the raw request
  logic [2:0]        req_sz;
  logic              req_legal;
  logic [ADDR_W-2:0] last_word;
  logic              req_err;

  always_comb begin
    req_sz = acc_size(bus.i_req_funct3[1:0]);
    if (bus.i_req_we)
      req_legal = (bus.i_req_funct3 == 3'b000) || (bus.i_req_funct3 == 3'b001) ||
                  (bus.i_req_funct3 == 3'b010);
    else
      req_legal = (bus.i_req_funct3 == 3'b000) || (bus.i_req_funct3 == 3'b001) ||
                  (bus.i_req_funct3 == 3'b010) || (bus.i_req_funct3 == 3'b100) ||
                  (bus.i_req_funct3 == 3'b101);
    // one extra bit so an access near the top of the address space cannot wrap
    last_word = (ADDR_W-1)'(({1'b0, bus.i_req_addr} + (ADDR_W+1)'(req_sz - 3'd1)) >> 2);
    req_err   = !req_legal || (last_word >= (ADDR_W-1)'(MEM_DEPTH));
  end

  // Lane placement derived from the captured request
  logic [2:0]        sz;
  logic [1:0]        off;
  logic [7:0]        m8;
  logic [63:0]       w64;
  logic              split;
  logic [MEM_AW-1:0] word_addr;

  always_comb begin
    sz        = acc_size(f3_q[1:0]);
    off       = addr_q[1:0];
    case (sz)
      3'd1:    m8 = 8'h01 << off;
      3'd2:    m8 = 8'h03 << off;
      default: m8 = 8'h0F << off;
    endcase
    w64       = {32'b0, wdata_q} << {off, 3'b000};
    split     = ({1'b0, off} + sz) > 3'd4;
    word_addr = addr_q[MEM_AW+1:2];
  end

  // Load data as it will look once the current access is captured
  logic [31:0] rd_lo, rd_hi, r, load_data;

  always_comb begin
    rd_lo = (state_q == ACC0) ? bus.i_mem_rdata : rd0_q;
    rd_hi = (state_q == ACC1) ? bus.i_mem_rdata : rd1_q;
    r     = 32'({rd_hi, rd_lo} >> {off, 3'b000});
    case (f3_q)
      3'b000:  load_data = {{24{r[7]}},  r[7:0]};
      3'b001:  load_data = {{16{r[15]}}, r[15:0]};
      3'b100:  load_data = {24'b0, r[7:0]};
      3'b101:  load_data = {16'b0, r[15:0]};
      default: load_data = r;
    endcase
    if (we_q) load_data = '0;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    f3_d            = f3_q;
    wdata_d         = wdata_q;
    rd0_d           = rd0_q;
    rd1_d           = rd1_q;
    rsp_rdata_d     = '0;
    rsp_err_d       = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_bmask = '0;
    bus.o_mem_wdata = '0;
    bus.o_mem_wren  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_req_valid) begin
        addr_d  = bus.i_req_addr[MEM_AW+1:0];
        we_d    = bus.i_req_we;
        f3_d    = bus.i_req_funct3;
        wdata_d = bus.i_req_wdata;
        rd0_d   = '0;
        rd1_d   = '0;
        if (req_err) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else begin
          state_d   = ACC0;
        end
      end
      ACC0: begin
        bus.o_mem_addr  = word_addr;
        bus.o_mem_bmask = m8[3:0];
        bus.o_mem_wdata = w64[31:0];
        bus.o_mem_wren  = we_q;
        rd0_d           = bus.i_mem_rdata;
        if (split) begin
          state_d     = ACC1;
        end else begin
          state_d     = RESP;
          rsp_rdata_d = load_data;
        end
      end
      ACC1: begin
        bus.o_mem_addr  = word_addr + MEM_AW'(1);
        bus.o_mem_bmask = m8[7:4];
        bus.o_mem_wdata = w64[63:32];
        bus.o_mem_wren  = we_q;
        rd1_d           = bus.i_mem_rdata;
        state_d         = RESP;
        rsp_rdata_d     = load_data;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      wdata_q     <= '0;
      rd0_q       <= '0;
      rd1_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      rd0_q       <= rd0_d;
      rd1_q       <= rd1_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: expected memory accesses and responses are
// queued at issue time and checked by an independent negedge monitor.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.ADDR_W(32), .MEM_AW(16)) bus();

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_AW(16), .MEM_DEPTH(64000)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          t0;
    string       nm;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
    logic        wren;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   pcnt   = 0;

  always @(posedge clk) pcnt <= pcnt + 1;

  // Memory model: combinational read, byte-masked write; preloaded on first edge
  logic [31:0] mem [0:255];
  logic        init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[5]    <= 32'h8899AABB;
      mem[6]    <= 32'h11223344;
      init_done <= 1'b1;
    end else if (bus.o_mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_bmask[b]) mem[bus.o_mem_addr[7:0]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
    end
  end

  assign bus.i_mem_rdata = mem[bus.o_mem_addr[7:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: memory-port accesses and response pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_mem_bmask != 4'b0 || bus.o_mem_wren) begin
        if (acc_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_mem_access: addr=%0h bmask=%b wren=%b", bus.o_mem_addr,
                   bus.o_mem_bmask, bus.o_mem_wren);
        end else begin
          acc_t a;
          a = acc_q.pop_front();
          chk("mem_addr_bmask_wren", {bus.o_mem_addr, bus.o_mem_bmask, bus.o_mem_wren},
              {a.addr, a.bmask, a.wren});
          chk("mem_wdata", bus.o_mem_wdata, a.wdata);
        end
      end
      if (bus.o_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: rdata=%0h err=%b", bus.o_rsp_rdata, bus.o_rsp_err);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk({e.nm, "_rdata"}, bus.o_rsp_rdata, e.rdata);
          chk({e.nm, "_err"}, bus.o_rsp_err, e.err);
          chk({e.nm, "_latency"}, pcnt - e.t0, e.lat);
        end
      end
    end
  end

  task automatic exp_acc(input logic [15:0] a, input logic [3:0] m, input logic [31:0] wd,
                         input logic we);
    acc_t x;
    x.addr = a; x.bmask = m; x.wdata = wd; x.wren = we;
    acc_q.push_back(x);
  endtask

  task automatic issue(input string nm, input logic [31:0] a, input logic we, input logic [2:0] f3,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat);
    rsp_t e;
    int   k;
    @(negedge clk);
    bus.i_req_addr   = a;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_req_wdata  = wd;
    bus.i_req_valid  = 1'b1;
    k = 0;
    while (!bus.o_req_ready && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) begin
      n_chk++; n_fail++;
      $display("FAIL %s_accept_timeout: ready=%b, expected 1", nm, bus.o_req_ready);
    end
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.t0 = pcnt; e.nm = nm;
    rsp_q.push_back(e);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    k = 0;
    while (rsp_q.size() != 0 && k < 20) begin @(negedge clk); k++; end
    if (rsp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_rsp_timeout: pending=%0d, expected 0", nm, rsp_q.size());
      rsp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req_valid  = 1'b0;
    bus.i_req_addr   = '0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = '0;
    bus.i_req_wdata  = '0;
    #2;
    chk("rst_ready", bus.o_req_ready, 1);
    chk("rst_rsp", {bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_rdata}, 0);
    chk("rst_mem", {bus.o_mem_addr, bus.o_mem_bmask, bus.o_mem_wren, bus.o_mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // aligned word and sub-word loads
    exp_acc(16'd5, 4'b1111, 32'h0, 1'b0);
    issue("lw_14",  32'h14, 1'b0, 3'b010, 32'h0, 32'h8899AABB, 1'b0, 2);
    exp_acc(16'd5, 4'b1000, 32'h0, 1'b0);
    issue("lb_17",  32'h17, 1'b0, 3'b000, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    exp_acc(16'd5, 4'b1000, 32'h0, 1'b0);
    issue("lbu_17", 32'h17, 1'b0, 3'b100, 32'h0, 32'h00000088, 1'b0, 2);
    exp_acc(16'd5, 4'b1100, 32'h0, 1'b0);
    issue("lh_16",  32'h16, 1'b0, 3'b001, 32'h0, 32'hFFFF8899, 1'b0, 2);
    exp_acc(16'd5, 4'b0011, 32'h0, 1'b0);
    issue("lhu_14", 32'h14, 1'b0, 3'b101, 32'h0, 32'h0000AABB, 1'b0, 2);

    // split load
    exp_acc(16'd5, 4'b1100, 32'h0, 1'b0);
    exp_acc(16'd6, 4'b0011, 32'h0, 1'b0);
    issue("lw_16_split", 32'h16, 1'b0, 3'b010, 32'h0, 32'h33448899, 1'b0, 3);

    // split store, then read back both words
    exp_acc(16'd5, 4'b1000, 32'hFE000000, 1'b1);
    exp_acc(16'd6, 4'b0001, 32'h000000CA, 1'b1);
    issue("sh_17_split", 32'h17, 1'b1, 3'b001, 32'h0000CAFE, 32'h0, 1'b0, 3);
    exp_acc(16'd5, 4'b1111, 32'h0, 1'b0);
    issue("lw_14_after_sh", 32'h14, 1'b0, 3'b010, 32'h0, 32'hFE99AABB, 1'b0, 2);
    exp_acc(16'd6, 4'b1111, 32'h0, 1'b0);
    issue("lw_18_after_sh", 32'h18, 1'b0, 3'b010, 32'h0, 32'h112233CA, 1'b0, 2);

    // byte store into lane 1
    exp_acc(16'd6, 4'b0010, 32'h0000A500, 1'b1);
    issue("sb_19", 32'h19, 1'b1, 3'b000, 32'h000000A5, 32'h0, 1'b0, 2);
    exp_acc(16'd6, 4'b1100, 32'h0, 1'b0);
    issue("lhu_1a", 32'h1A, 1'b0, 3'b101, 32'h0, 32'h00001122, 1'b0, 2);

    // errors: no memory access may appear for any of these
    issue("ld_f3_011",   32'h14,       1'b0, 3'b011, 32'h0,        32'h0, 1'b1, 1);
    issue("sw_word64000", 32'h3E800,   1'b1, 3'b010, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    issue("lh_3e7ff_end", 32'h3E7FF,   1'b0, 3'b001, 32'h0,        32'h0, 1'b1, 1);
    issue("lw_high_bits", 32'h80000014, 1'b0, 3'b010, 32'h0,       32'h0, 1'b1, 1);
    issue("st_f3_100",   32'h14,       1'b1, 3'b100, 32'h12345678, 32'h0, 1'b1, 1);
    // last legal word
    exp_acc(16'hF9FF, 4'b1111, 32'h0, 1'b0);
    issue("lw_3e7fc_last", 32'h3E7FC, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 2);

    // reset during ACC1 of a split store: first word stays written
    exp_acc(16'd5, 4'b1000, 32'hEF000000, 1'b1);
    @(negedge clk);
    bus.i_req_addr   = 32'h17;
    bus.i_req_we     = 1'b1;
    bus.i_req_funct3 = 3'b001;
    bus.i_req_wdata  = 32'h0000BEEF;
    bus.i_req_valid  = 1'b1;
    @(negedge clk);
    bus.i_req_valid  = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wren_rspvalid", {bus.o_mem_wren, bus.o_rsp_valid}, 0);
    chk("midrst_mem_bus", {bus.o_mem_addr, bus.o_mem_bmask, bus.o_mem_wdata}, 0);
    chk("midrst_ready", bus.o_req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_acc_pending", acc_q.size(), 0);
    chk("postrst_ready", bus.o_req_ready, 1);
    exp_acc(16'd5, 4'b1111, 32'h0, 1'b0);
    issue("lw_14_postrst", 32'h14, 1'b0, 3'b010, 32'h0, 32'hEF99AABB, 1'b0, 2);
    exp_acc(16'd6, 4'b1111, 32'h0, 1'b0);
    issue("lw_18_postrst", 32'h18, 1'b0, 3'b010, 32'h0, 32'h1122A5CA, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("final_acc_pending", acc_q.size(), 0);
    chk("final_rsp_pending", rsp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
